// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time loader: framed byte stream into 16-bit program memory words, XOR-checked
module program_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 5,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  byte_ready,
    input  logic                  reload,
    output logic                  pm_we,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic [INSTR_WIDTH-1:0] pm_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   loaded_count
);

    localparam int CNT_W    = ADDR_WIDTH + 1;
    localparam int CAPACITY = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HDR,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        n_reg;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [BYTE_WIDTH-1:0]   chk;
    logic [BYTE_WIDTH-1:0]   hi_reg;
    logic                    hdr_ok;
    logic                    last_word;

    assign hdr_ok    = (byte_data != '0) && (32'(byte_data) <= CAPACITY);
    assign last_word = (loaded_count + CNT_W'(1)) == n_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        pm_we      = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            S_HDR: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = hdr_ok ? S_HI : S_ERR;
                end
            end
            S_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = S_WR;
                end
            end
            S_WR: begin
                pm_we      = 1'b1;
                state_next = last_word ? S_CHK : S_HI;
            end
            S_CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = (byte_data == chk) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (reload) begin
                    state_next = S_HDR;
                end
            end
            S_ERR: begin
                error = 1'b1;
                if (reload) begin
                    state_next = S_HDR;
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    // pm_addr/pm_wdata are loaded on the low-byte transfer so they are stable
    // through the WR cycle and keep their value afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg        <= '0;
            addr         <= '0;
            chk          <= '0;
            hi_reg       <= '0;
            pm_addr      <= '0;
            pm_wdata     <= '0;
            loaded_count <= '0;
        end else begin
            case (state)
                S_HDR: begin
                    if (byte_valid && hdr_ok) begin
                        n_reg        <= CNT_W'(byte_data);
                        addr         <= '0;
                        chk          <= '0;
                        loaded_count <= '0;
                    end
                end
                S_HI: begin
                    if (byte_valid) begin
                        hi_reg <= byte_data;
                        chk    <= chk ^ byte_data;
                    end
                end
                S_LO: begin
                    if (byte_valid) begin
                        chk      <= chk ^ byte_data;
                        pm_addr  <= addr;
                        pm_wdata <= {hi_reg, byte_data};
                    end
                end
                S_WR: begin
                    loaded_count <= loaded_count + CNT_W'(1);
                    addr         <= addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
